// File: rtl/data_bus_ram_slave.sv
// Word-organised RAM slave: byte/word reads and writes over a four-phase ready handshake.
// Latency: ready and read data valid WAIT_STATES falling edges after the request is sampled.
// Backpressure: ready stays high until the master drops read/write; new requests are sampled only in IDLE.
//
// Ports:
//   clk      bus clock from the master; all slave state changes on its falling edge
//   rst      asynchronous active-high reset
//   addr     byte address (word index = addr[ADDR_BITS+1:2], lane = addr[1:0])
//   dataOut  write data from the master
//   dataIn   read data to the master; updated only when a read completes
//   read     read request
//   write    write request
//   memType  access size: 3'd0 = BYTE, any other encoding is a WORD access
//   ready    transfer complete, held until the request is released
module data_bus_ram_slave #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] dataOut,
    output logic [31:0] dataIn,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  memType,
    output logic        ready
);

    localparam int          DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);
    localparam logic [2:0]  MEM_BYTE = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             wcnt;

    // Request captured at acceptance; WAIT never re-samples the bus.
    logic                   lat_write;
    logic                   lat_byte;
    logic [ADDR_BITS-1:0]   lat_idx;
    logic [1:0]             lat_lane;
    logic [31:0]            lat_data;

    logic [31:0]            mem [0:DEPTH-1];

    logic                   in_idle;
    logic                   req_ok;
    logic                   accept;
    logic                   do_access;
    logic                   acc_write;
    logic                   acc_byte;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic [1:0]             acc_lane;
    logic [31:0]            acc_data;
    logic [31:0]            rd_word;
    logic [7:0]             rd_byte;

    // Upper address bits are ignored on purpose: the RAM aliases across the address space.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_BITS+2];

    assign in_idle = (state == S_IDLE);
    assign req_ok  = read ^ write;   // both high is illegal and ignored
    assign accept  = in_idle && req_ok;

    // With zero wait states the access happens on the accepting edge using the live
    // bus values; otherwise it uses the values latched at acceptance.
    always_comb begin
        if (in_idle) begin
            acc_write = write;
            acc_byte  = (memType == MEM_BYTE);
            acc_idx   = addr[ADDR_BITS+1:2];
            acc_lane  = addr[1:0];
            acc_data  = dataOut;
        end else begin
            acc_write = lat_write;
            acc_byte  = lat_byte;
            acc_idx   = lat_idx;
            acc_lane  = lat_lane;
            acc_data  = lat_data;
        end
    end

    // rst gates the access so a pending write is dropped whenever reset is active.
    assign do_access = !rst &&
                       ((accept && (WS == 4'd0)) || ((state == S_WAIT) && (wcnt == 4'd1)));

    assign rd_word = mem[acc_idx];
    assign rd_byte = rd_word[{acc_lane, 3'b000} +: 8];

    // State register
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_ok) begin
                    state_nxt = (WS == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt == 4'd1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!read && !write) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: ready is a pure function of state, so reset drops it at once.
    always_comb begin
        ready = (state == S_DONE);
    end

    // Request latch, wait counter and read-data register
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wcnt      <= 4'd0;
            dataIn    <= 32'd0;
            lat_write <= 1'b0;
            lat_byte  <= 1'b0;
            lat_idx   <= '0;
            lat_lane  <= 2'd0;
            lat_data  <= 32'd0;
        end else begin
            if (accept) begin
                lat_write <= write;
                lat_byte  <= (memType == MEM_BYTE);
                lat_idx   <= addr[ADDR_BITS+1:2];
                lat_lane  <= addr[1:0];
                lat_data  <= dataOut;
                wcnt      <= WS;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end

            if (do_access && !acc_write) begin
                dataIn <= acc_byte ? {24'd0, rd_byte} : rd_word;
            end
        end
    end

    // RAM array: contents survive reset; written only on the completing edge.
    always_ff @(negedge clk) begin
        if (do_access && acc_write) begin
            if (acc_byte) begin
                mem[acc_idx][{acc_lane, 3'b000} +: 8] <= acc_data[7:0];
            end else begin
                mem[acc_idx] <= acc_data;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_ram_slave.sv
// Directed bench for data_bus_ram_slave with three instances: WAIT_STATES 0, 1 and 3.
// The master drives on rising edges; ready/dataIn are checked 1 ns after falling edges
// or on rising edges, never on the falling edge where the slave updates.
module tb_data_bus_ram_slave;

    localparam logic [2:0] BYTE = 3'd0;
    localparam logic [2:0] WORD = 3'd2;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr [3];
    logic [31:0] dout [3];
    logic [2:0]  mt   [3];
    wire  [2:0]  rdy;
    wire  [31:0] din  [3];

    int n_cmp = 0;
    int n_bad = 0;

    data_bus_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst[0]), .addr(addr[0]), .dataOut(dout[0]), .dataIn(din[0]),
        .read(rd[0]), .write(wr[0]), .memType(mt[0]), .ready(rdy[0])
    );
    data_bus_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst[1]), .addr(addr[1]), .dataOut(dout[1]), .dataIn(din[1]),
        .read(rd[1]), .write(wr[1]), .memType(mt[1]), .ready(rdy[1])
    );
    data_bus_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst[2]), .addr(addr[2]), .dataOut(dout[2]), .dataIn(din[2]),
        .read(rd[2]), .write(wr[2]), .memType(mt[2]), .ready(rdy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request on the next rising edge.
    task automatic start_req(input int i, input logic r, input logic w, input logic [2:0] m,
                             input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        rd[i] = r; wr[i] = w; mt[i] = m; addr[i] = a; dout[i] = d;
    endtask

    // Count falling edges until ready is seen (bounded at 40).
    task automatic wait_ready(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!rdy[i] && n < 40);
    endtask

    // Drop the request on a rising edge and return just after the next falling edge.
    task automatic release_req(input int i);
        @(posedge clk);
        rd[i] = 1'b0; wr[i] = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset;
        int n;
        #2;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 0", i, rdy[i]); end
            n_cmp++;
            if (din[i] !== 32'd0) begin n_bad++; $display("FAIL reset_dataIn[%0d]: got %h want 0", i, din[i]); end
        end
        @(posedge clk);
        rst = 3'b000;

        // Establish a known word at 0x10 in the 3-wait instance.
        start_req(2, 1'b0, 1'b1, WORD, 32'h10, 32'h0BADF00D);
        wait_ready(2, n);
        n_cmp++;
        if (n !== 4) begin n_bad++; $display("FAIL ws3_write_latency: got %0d want 4", n); end
        release_req(2);
        start_req(2, 1'b1, 1'b0, WORD, 32'h10, 32'h0);
        wait_ready(2, n);
        n_cmp++;
        if (n !== 4 || din[2] !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL ws3_read: lat %0d data %h want 4 0badf00d", n, din[2]);
        end
        release_req(2);

        // Start a write, then reset between edges while it sits in WAIT.
        start_req(2, 1'b0, 1'b1, WORD, 32'h10, 32'h11111111);
        @(negedge clk);
        @(negedge clk);
        #2 rst[2] = 1'b1;
        #1;
        n_cmp++;
        if (rdy[2] !== 1'b0) begin n_bad++; $display("FAIL midwait_reset_ready: got %b want 0", rdy[2]); end
        n_cmp++;
        if (din[2] !== 32'd0) begin n_bad++; $display("FAIL midwait_reset_dataIn: got %h want 0", din[2]); end
        wr[2] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        rst[2] = 1'b0;

        start_req(2, 1'b1, 1'b0, WORD, 32'h10, 32'h0);
        wait_ready(2, n);
        n_cmp++;
        if (din[2] !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL aborted_write_landed: got %h want 0badf00d", din[2]);
        end
        release_req(2);
    endtask

    task automatic test_word_rw;
        int n;
        start_req(1, 1'b0, 1'b1, WORD, 32'h10, 32'hDEADBEEF);
        wait_ready(1, n);
        n_cmp++;
        if (n !== 2) begin n_bad++; $display("FAIL ws1_write_latency: got %0d want 2", n); end
        release_req(1);
        n_cmp++;
        if (rdy[1] !== 1'b0) begin n_bad++; $display("FAIL ws1_release: got %b want 0", rdy[1]); end
        start_req(1, 1'b1, 1'b0, WORD, 32'h10, 32'h0);
        wait_ready(1, n);
        n_cmp++;
        if (n !== 2 || din[1] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL ws1_word_read: lat %0d data %h want 2 deadbeef", n, din[1]);
        end
        release_req(1);
    endtask

    task automatic test_byte_lanes;
        int n;
        start_req(1, 1'b0, 1'b1, BYTE, 32'h12, 32'h123456A5);
        wait_ready(1, n);
        n_cmp++;
        if (din[1] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL dataIn_hold_on_write: got %h want deadbeef", din[1]);
        end
        release_req(1);
        start_req(1, 1'b1, 1'b0, WORD, 32'h10, 32'h0);
        wait_ready(1, n);
        n_cmp++;
        if (din[1] !== 32'hDEA5BEEF) begin
            n_bad++; $display("FAIL byte_write_merge: got %h want dea5beef", din[1]);
        end
        release_req(1);
        start_req(1, 1'b1, 1'b0, BYTE, 32'h13, 32'h0);
        wait_ready(1, n);
        n_cmp++;
        if (din[1] !== 32'h000000DE) begin
            n_bad++; $display("FAIL byte_read_lane3: got %h want 000000de", din[1]);
        end
        release_req(1);
    endtask

    task automatic test_handshake_hold;
        int n;
        start_req(1, 1'b1, 1'b0, WORD, 32'h10, 32'h0);
        wait_ready(1, n);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            n_cmp++;
            if (rdy[1] !== 1'b1 || din[1] !== 32'hDEA5BEEF) begin
                n_bad++; $display("FAIL hold_cycle%0d: ready %b data %h want 1 dea5beef", k, rdy[1], din[1]);
            end
        end
        release_req(1);
        n_cmp++;
        if (rdy[1] !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %b want 0", rdy[1]); end
        // New request raised on the edge where ready fell: sampled only at the following edge.
        rd[1] = 1'b1; wr[1] = 1'b0; mt[1] = BYTE; addr[1] = 32'h11;
        wait_ready(1, n);
        n_cmp++;
        if (n !== 2 || din[1] !== 32'h000000BE) begin
            n_bad++; $display("FAIL post_release_req: lat %0d data %h want 2 000000be", n, din[1]);
        end
        release_req(1);
    endtask

    task automatic test_illegal;
        int n;
        start_req(1, 1'b1, 1'b1, WORD, 32'h10, 32'h55555555);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (rdy[1] !== 1'b0) begin n_bad++; $display("FAIL illegal_ready%0d: got %b want 0", k, rdy[1]); end
        end
        @(posedge clk);
        rd[1] = 1'b0; wr[1] = 1'b0;
        start_req(1, 1'b1, 1'b0, WORD, 32'h10, 32'h0);
        wait_ready(1, n);
        n_cmp++;
        if (din[1] !== 32'hDEA5BEEF) begin
            n_bad++; $display("FAIL illegal_no_write: got %h want dea5beef", din[1]);
        end
        release_req(1);
    endtask

    task automatic test_zero_wait;
        int n;
        start_req(0, 1'b0, 1'b1, WORD, 32'h1010, 32'h12345678);
        wait_ready(0, n);
        n_cmp++;
        if (n !== 1) begin n_bad++; $display("FAIL ws0_write_latency: got %0d want 1", n); end
        release_req(0);
        n_cmp++;
        if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL ws0_release: got %b want 0", rdy[0]); end
        start_req(0, 1'b1, 1'b0, WORD, 32'h10, 32'h0);
        wait_ready(0, n);
        n_cmp++;
        if (n !== 1 || din[0] !== 32'h12345678) begin
            n_bad++; $display("FAIL alias_read: lat %0d data %h want 1 12345678", n, din[0]);
        end
        release_req(0);
        start_req(0, 1'b1, 1'b0, BYTE, 32'h1011, 32'h0);
        wait_ready(0, n);
        n_cmp++;
        if (din[0] !== 32'h00000056) begin
            n_bad++; $display("FAIL ws0_byte_lane1: got %h want 00000056", din[0]);
        end
        release_req(0);
        // Non-BYTE encoding acts as WORD and ignores addr[1:0].
        start_req(0, 1'b1, 1'b0, 3'd5, 32'h13, 32'h0);
        wait_ready(0, n);
        n_cmp++;
        if (din[0] !== 32'h12345678) begin
            n_bad++; $display("FAIL other_memtype_word: got %h want 12345678", din[0]);
        end
        release_req(0);
    endtask

    initial begin
        rst = 3'b111;
        rd  = 3'b000;
        wr  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 32'd0; dout[i] = 32'd0; mt[i] = WORD;
        end
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_handshake_hold();
        test_illegal();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
